// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram-like request arbiter: source tags,
// transfer size codes and the lock state encoding.
package sram_req_arbiter_pkg;
  // Source tag stored per outstanding transaction
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // sram-like transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Starvation counter saturates here (4-bit counter)
  localparam logic [3:0] STARVE_SAT = 4'd15;

  typedef enum logic {LK_FREE, LK_HELD} lock_state_t;
endpackage

// File: rtl/sram_req_arbiter_if.sv
// One sram-like split-transaction port. The master side presents the
// request; the slave side answers with addr_ok / data_ok / rdata.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter_resp_order_fifo.sv
// Tag FIFO remembering which requester issued each outstanding transaction,
// so responses can be steered back in issue order.
module resp_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   din,
  output logic                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] tags;
  logic [AW-1:0]    wptr, rptr;

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tags[wptr] <= din;
        wptr       <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = tags[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch and data access.
// Address phases are arbitrated (data first, inst after a starvation limit),
// a stalled grant is locked until accepted, and responses are returned to
// their issuer strictly in issue order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                clk,
  input  logic                resetn,
  sram_req_arbiter_if.slave   inst,
  sram_req_arbiter_if.slave   data,
  sram_req_arbiter_if.master  mem,
  output logic                err_unexp_ok
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  lock_state_t lock_state, lock_state_n;
  logic        lock_sel, lock_sel_n;
  logic [3:0]  starve_cnt;
  logic        sel_valid, sel, sel_req, hs;
  logic        fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Pick the requester: a held lock wins, else data unless inst is starving
  always_comb begin
    sel_valid = 1'b0;
    sel       = SRC_INST;
    if (lock_state == LK_HELD) begin
      sel_valid = 1'b1;
      sel       = lock_sel;
    end else if (inst.req && (!data.req || starve_cnt >= 4'(STARVE_LIMIT))) begin
      sel_valid = 1'b1;
      sel       = SRC_INST;
    end else if (data.req) begin
      sel_valid = 1'b1;
      sel       = SRC_DATA;
    end
  end

  assign sel_req = sel_valid && ((sel == SRC_INST) ? inst.req : data.req);
  // A full FIFO blocks issue even if a pop happens the same cycle
  assign mem.req = resetn && sel_req && (fifo_count < CW'(MAX_OUTSTANDING));
  assign hs      = mem.req && mem.addr_ok;

  // Request field mux, zero when nobody is selected
  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = SIZE_BYTE;
    mem.wstrb = '0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (sel_valid) begin
      if (sel == SRC_INST) begin
        mem.wr = inst.wr; mem.size = inst.size; mem.wstrb = inst.wstrb;
        mem.addr = inst.addr; mem.wdata = inst.wdata;
      end else begin
        mem.wr = data.wr; mem.size = data.size; mem.wstrb = data.wstrb;
        mem.addr = data.addr; mem.wdata = data.wdata;
      end
    end
  end

  assign inst.addr_ok = hs && (sel == SRC_INST);
  assign data.addr_ok = hs && (sel == SRC_DATA);

  // Lock state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state <= LK_FREE;
      lock_sel   <= SRC_INST;
    end else begin
      lock_state <= lock_state_n;
      lock_sel   <= lock_sel_n;
    end
  end

  // Lock a presented-but-unaccepted grant so the request stays stable
  always_comb begin
    lock_state_n = lock_state;
    lock_sel_n   = lock_sel;
    if (mem.addr_ok) begin
      lock_state_n = LK_FREE;
    end else if (mem.req) begin
      lock_state_n = LK_HELD;
      lock_sel_n   = sel;
    end
  end

  // Count consecutive cycles inst waits while requesting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           starve_cnt <= '0;
    else if (!inst.req || inst.addr_ok)    starve_cnt <= '0;
    else if (starve_cnt != STARVE_SAT)     starve_cnt <= starve_cnt + 1'b1;
  end

  assign fifo_push = hs;
  assign fifo_pop  = mem.data_ok && !fifo_empty;

  resp_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sel),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue is gated on occupancy, so a push never lands on a full FIFO
  assert property (@(posedge clk) disable iff (!resetn) !(fifo_push && fifo_full));

  // Steer the response to whoever issued the oldest outstanding request
  assign inst.data_ok = fifo_pop && (fifo_head == SRC_INST);
  assign data.data_ok = fifo_pop && (fifo_head == SRC_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // Sticky flag for a response with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       err_unexp_ok <= 1'b0;
    else if (mem.data_ok && fifo_empty) err_unexp_ok <= 1'b1;
  end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one sram-like memory port (req/addr_ok/data_ok split-transaction protocol) between the CPU's instruction-fetch and data-access requesters. It sits between the CPU top's inst_sram/data_sram interfaces and a single downstream bridge or memory. It arbitrates address phases, holds each grant until accepted, and records issue order. It returns data_ok/rdata to the requester that issued each transaction, strictly in order.

Parameters:
MAX_OUTSTANDING, 4, depth of the in-order response-tag FIFO; power of two, 2..16.
STARVE_LIMIT, 3, consecutive cycles inst may be denied while requesting before it gets forced priority; 1..15.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req / inst_wr  in  1 / 1  inst requester request, write flag
inst_size / inst_wstrb  in  2 / 4  transfer size, byte strobes
inst_addr / inst_wdata  in  32 / 32  address, write data
inst_addr_ok / inst_data_ok  out  1 / 1  address accepted, response valid
inst_rdata  out  32  response data
data_req … data_rdata  same set and widths as inst_*, for the data requester
mem_req / mem_wr  out  1 / 1  to shared port
mem_size / mem_wstrb / mem_addr / mem_wdata  out  2 / 4 / 32 / 32  muxed request fields
mem_addr_ok / mem_data_ok  in  1 / 1  from shared port
mem_rdata  in  32  response data
err_unexp_ok  out  1  sticky: mem_data_ok seen with empty FIFO

Behaviour:
- Reset (async assert, sync deassert by user): lock_valid=0, starve_cnt=0, FIFO count=0, err_unexp_ok=0. All outputs are combinational from this state, so mem_req=0 and *_addr_ok=*_data_ok=0 while resetn=0.
- Selection when lock_valid=0:
  - sel = INST if inst_req and (!data_req or starve_cnt>=STARVE_LIMIT).
  - Else sel = DATA if data_req.
  - Else no request.
- When lock_valid=1: sel = lock_sel, regardless of the other request.
- mem_req = selected requester's req && fifo_count<MAX_OUTSTANDING.
  - Full blocks issue even if a pop occurs the same cycle (deliberately conservative).
- mem_wr/size/wstrb/addr/wdata = selected requester's fields, zero when no selection.
- Selected *_addr_ok = mem_addr_ok && mem_req. The unselected addr_ok = 0.
- Lock: if mem_req && !mem_addr_ok, set lock_valid=1 and lock_sel=sel. Clear lock_valid on the cycle mem_addr_ok=1. This keeps the sram-like rule that a presented request stays stable until accepted.
- Handshake acceptance (mem_req && mem_addr_ok) pushes a 1-bit source tag into the FIFO. The handshake completes in the same cycle; issue latency is 0 cycles.
- mem_data_ok with FIFO non-empty:
  - Pop the head tag.
  - Assert that source's *_data_ok in the same cycle (combinational).
  - *_rdata = mem_rdata for both outputs; only the tagged data_ok is high.
- mem_data_ok with FIFO empty: ignored, err_unexp_ok<=1 (sticky until reset).
- Simultaneous push and pop: count unchanged, write and read pointers both advance. Pointers wrap modulo MAX_OUTSTANDING.
- starve_cnt:
  - Resets to 0 when inst gets addr_ok or inst_req=0.
  - Otherwise increments, saturating at 15, each cycle inst_req=1 without inst_addr_ok.
- Reset mid-operation clears the FIFO and lock. Responses arriving after reset release are treated as unexpected.
- One transaction per cycle maximum. Responses are returned strictly in issue order; the arbiter does no reordering.

Decomposition:
- Shared package (cpu defines header): SRC_INST=1'b0, SRC_DATA=1'b1, and the sram-like size codes (0 byte, 1 half, 2 word).
- Sub-module resp_order_fifo: parameterised-depth 1-bit tag FIFO with push, pop, head, count, full and empty.
- The arbiter holds the lock register, starvation counter, request mux and response demux.

Test Plan:
- Only inst_req=1, addr 0x1c000000, mem_addr_ok=1 same cycle -> mem_addr=0x1c000000, inst_addr_ok=1. Next cycle mem_data_ok=1, rdata=0x02800c06 -> inst_data_ok=1 with that data, data_data_ok=0.
- Both req; data addr 0x80, wr=1, wstrb=4'hf; mem_addr_ok low 2 cycles -> mem_addr holds 0x80 all 3 cycles even though inst_req persists; data_addr_ok only in cycle 3.
- Continuous data_req plus inst_req, mem_addr_ok=1 always, STARVE_LIMIT=3 -> inst wins on the 4th cycle. Grant sequence D,D,D,I repeats.
- Issue I,D,I,D with no responses, then a 5th request -> mem_req=0 (FIFO full). Four mem_data_ok pulses then yield data_ok on inst,data,inst,data in order.
- mem_data_ok with no outstanding -> no data_ok asserted, err_unexp_ok=1 and held. Then resetn=0 mid-lock with 2 outstanding -> count=0, lock cleared, err_unexp_ok=0 immediately.
